rom_seq_multiplier: RTL

Parametrised sequential unsigned multiplier built around a small digit-product ROM. Each WIDTH-bit operand is split into DIGIT-bit digits. Every cycle, one digit pair is looked up in the ROM and the result is shift-accumulated into a 2·WIDTH-bit product. It is the multi-cycle, arbitrary-width successor of the 2×2 ROM multiplier and uses a start/busy/done handshake so a controller or FSM can sequence it.

---
 rtl/rom_seq_multiplier_pkg.sv | 13 +
 rtl/rom_seq_multiplier_if.sv | 12 +
 rtl/rom_seq_multiplier_rom.sv | 18 +
 rtl/rom_seq_multiplier.sv | 87 ++++++++
 4 files changed

// File: rtl/rom_seq_multiplier_pkg.sv
// Shared types and helpers for the digit-ROM sequential multiplier.
package rom_mult_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Number of DIGIT-bit digits in a WIDTH-bit operand.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction
endpackage

// File: rtl/rom_seq_multiplier_if.sv
// Start/busy/done handshake bundle between a controller and the multiplier.
interface rom_seq_multiplier_if #(parameter int WIDTH = 8);
    logic                 start;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multicand;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, multiplier, multicand, input busy, done, product);
    modport slave  (input start, multiplier, multicand, output busy, done, product);
endinterface

// File: rtl/rom_seq_multiplier_rom.sv
// Digit-product lookup table; contents a*b built at elaboration, no memory file.
module digit_product_rom #(
    parameter int DIGIT = 2
) (
    input  logic [2*DIGIT-1:0] addr,
    output logic [2*DIGIT-1:0] data
);
    localparam int WORDS = 1 << (2*DIGIT);

    logic [2*DIGIT-1:0] rom [WORDS];

    // Upper DIGIT address bits are digit a, lower DIGIT bits are digit b.
    for (genvar k = 0; k < WORDS; k++) begin : g_word
        assign rom[k] = (2*DIGIT)'((k >> DIGIT) * (k % (1 << DIGIT)));
    end

    assign data = rom[addr];
endmodule

// File: rtl/rom_seq_multiplier.sv
// Sequential unsigned multiplier: one digit-pair ROM lookup shift-accumulated per cycle.
module rom_seq_multiplier
    import rom_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    rom_seq_multiplier_if.slave bus
);
    localparam int              K    = num_digits(WIDTH, DIGIT);
    localparam int              CW   = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0]   LAST = CW'(K - 1);

    state_t               state;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [CW-1:0]        i_q, j_q;
    logic [2*WIDTH-1:0]   acc, acc_nxt, product_q;
    logic                 busy_q, done_q;
    logic [DIGIT-1:0]     a_dig, b_dig;
    logic [2*DIGIT-1:0]   rom_data;
    int                   shamt;

    assign a_dig = a_q[int'(i_q)*DIGIT +: DIGIT];
    assign b_dig = b_q[int'(j_q)*DIGIT +: DIGIT];

    digit_product_rom #(.DIGIT(DIGIT)) u_rom (
        .addr ({a_dig, b_dig}),
        .data (rom_data)
    );

    // Digit weight is DIGIT*(i+j); computed as int so i+j cannot wrap.
    assign shamt   = DIGIT * (int'(i_q) + int'(j_q));
    assign acc_nxt = acc + ((2*WIDTH)'(rom_data) << shamt);

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.multiplier;
                        b_q    <= bus.multicand;
                        acc    <= '0;
                        i_q    <= '0;
                        j_q    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (i_q == LAST && j_q == LAST) begin
                        product_q <= acc_nxt;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end else if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
